// File: rtl/bin_to_bcd_pkg.sv
// rtl/bin_to_bcd_pkg.sv - shared FSM state type and BCD digit-adjust function
package bin_to_bcd_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CONV = 2'd1,
        S_DONE = 2'd2
    } state_t;

    // Double-dabble correction: a digit of 5..9 must carry into the next digit after doubling.
    function automatic logic [3:0] add3(input logic [3:0] d);
        return (d >= 4'd5) ? (d + 4'd3) : d;
    endfunction

endpackage

// File: rtl/bcd_add3.sv
// rtl/bcd_add3.sv - combinational add-3 adjust for one BCD digit
module bcd_add3
    import bin_to_bcd_pkg::*;
(
    input  logic [3:0] d_i,
    output logic [3:0] d_o
);

    assign d_o = add3(d_i);

endmodule

// File: rtl/bin_to_bcd_param.sv
// rtl/bin_to_bcd_param.sv - sequential double-dabble binary to BCD converter
// Optional two's complement input when BIN_TO_BCD_SIGNED_EN is defined.
module bin_to_bcd_param
    import bin_to_bcd_pkg::*;
#(
    parameter int BIN_W  = 16,
    parameter int DIGITS = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [BIN_W-1:0]      bin,
    output logic                  ready,
    output logic                  done_tick,
    output logic [4*DIGITS-1:0]   bcd,
    output logic                  overflow,
    output logic                  neg
);

    localparam int CNT_W = $clog2(BIN_W + 1);
    localparam int BCD_W = 4 * DIGITS;

    state_t             state_q, state_d;
    logic [BIN_W-1:0]   shift_q, shift_d;
    logic [BCD_W-1:0]   work_q, work_d;
    logic               ovf_q, ovf_d;
    logic               sign_q, sign_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [BCD_W-1:0]   bcd_q, bcd_d;
    logic               overflow_q, overflow_d;
    logic               neg_q, neg_d;

    logic [BCD_W-1:0]   adj;
    logic [BCD_W-1:0]   shifted;
    logic [BIN_W-1:0]   mag;
    logic               bin_neg;

`ifdef BIN_TO_BCD_SIGNED_EN
    // The most negative value negates to itself, which read unsigned is the right magnitude.
    assign bin_neg = bin[BIN_W-1];
    assign mag     = bin_neg ? (~bin + BIN_W'(1)) : bin;
`else
    assign bin_neg = 1'b0;
    assign mag     = bin;
`endif

    for (genvar g = 0; g < DIGITS; g++) begin : g_adj
        bcd_add3 u_add3 (
            .d_i (work_q[4*g +: 4]),
            .d_o (adj[4*g +: 4])
        );
    end

    if (BCD_W > 1) begin : g_shl
        assign shifted = {adj[BCD_W-2:0], shift_q[BIN_W-1]};
    end else begin : g_shl1
        assign shifted = shift_q[BIN_W-1];
    end

    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        work_d     = work_q;
        ovf_d      = ovf_q;
        sign_d     = sign_q;
        cnt_d      = cnt_q;
        bcd_d      = bcd_q;
        overflow_d = overflow_q;
        neg_d      = neg_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    shift_d = mag;
                    work_d  = '0;
                    ovf_d   = 1'b0;
                    sign_d  = bin_neg;
                    cnt_d   = CNT_W'(BIN_W);
                    state_d = S_CONV;
                end
            end
            S_CONV: begin
                work_d  = shifted;
                shift_d = shift_q << 1;
                ovf_d   = ovf_q | adj[BCD_W-1];
                cnt_d   = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    bcd_d      = shifted;
                    overflow_d = ovf_q | adj[BCD_W-1];
                    neg_d      = sign_q;
                    state_d    = S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            shift_q    <= '0;
            work_q     <= '0;
            ovf_q      <= 1'b0;
            sign_q     <= 1'b0;
            cnt_q      <= '0;
            bcd_q      <= '0;
            overflow_q <= 1'b0;
            neg_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            work_q     <= work_d;
            ovf_q      <= ovf_d;
            sign_q     <= sign_d;
            cnt_q      <= cnt_d;
            bcd_q      <= bcd_d;
            overflow_q <= overflow_d;
            neg_q      <= neg_d;
        end
    end

    assign ready     = (state_q == S_IDLE);
    assign done_tick = (state_q == S_DONE);
    assign bcd       = bcd_q;
    assign overflow  = overflow_q;
    assign neg       = neg_q;

endmodule
